// File: rtl/serial_alu_pkg.sv
// Shared control encodings for the serial ALU: opcode width, opcode values,
// sequencer state encoding and a helper that classifies opcodes.
// Ports: none (package). `CONTROL_WIDTH is the tile-wide opcode width macro.
`ifndef CONTROL_WIDTH
`define CONTROL_WIDTH 4
`endif

package serial_alu_pkg;

   localparam int CONTROL_WIDTH = `CONTROL_WIDTH;

   typedef logic [CONTROL_WIDTH-1:0] ctrl_t;

   // Opcode encodings; every code not listed here yields a zero result.
   localparam ctrl_t OUTPUT_ALL_ZERO  = ctrl_t'(0);
   localparam ctrl_t OUTPUT_A_PLUS_B  = ctrl_t'(1);
   localparam ctrl_t OUTPUT_A_MINUS_B = ctrl_t'(2);
   localparam ctrl_t OUTPUT_A_AND_B   = ctrl_t'(3);
   localparam ctrl_t OUTPUT_A_OR_B    = ctrl_t'(4);
   localparam ctrl_t OUTPUT_A_XOR_B   = ctrl_t'(5);
   localparam ctrl_t OUTPUT_NOT_A     = ctrl_t'(6);
   localparam ctrl_t OUTPUT_A         = ctrl_t'(7);
   localparam ctrl_t OUTPUT_B         = ctrl_t'(8);
   localparam ctrl_t OUTPUT_ALL_ONE   = ctrl_t'(9);

   // Sequencer states.
   typedef enum logic [1:0] {
      SERIAL_IDLE = 2'd0,
      SERIAL_RUN  = 2'd1,
      SERIAL_DONE = 2'd2
   } state_t;

   function automatic logic is_arith(input ctrl_t f);
      return (f == OUTPUT_A_PLUS_B) || (f == OUTPUT_A_MINUS_B);
   endfunction

endpackage

// File: rtl/one_bit_alu.sv
// One-bit ALU slice: purely combinational, evaluates one bit position.
// Ports: a/b operand bits, carry_in/borrow_in from previous bit, f opcode;
//        result bit, carry_out/borrow_out for the next bit. No backpressure.
module one_bit_alu
   import serial_alu_pkg::*;
(
   input  logic  a,
   input  logic  b,
   input  logic  carry_in,
   input  logic  borrow_in,
   input  ctrl_t f,
   output logic  result,
   output logic  carry_out,
   output logic  borrow_out
);

   always_comb begin
      result     = 1'b0;
      carry_out  = 1'b0;
      borrow_out = 1'b0;
      case (f)
         OUTPUT_A_PLUS_B: begin
            result    = a ^ b ^ carry_in;
            carry_out = (a & b) | (carry_in & (a ^ b));
         end
         OUTPUT_A_MINUS_B: begin
            result     = a ^ b ^ borrow_in;
            // Borrow when b (plus incoming borrow) exceeds a at this bit.
            borrow_out = (~a & b) | (borrow_in & ~(a ^ b));
         end
         OUTPUT_A_AND_B: result = a & b;
         OUTPUT_A_OR_B:  result = a | b;
         OUTPUT_A_XOR_B: result = a ^ b;
         OUTPUT_NOT_A:   result = ~a;
         OUTPUT_A:       result = a;
         OUTPUT_B:       result = b;
         OUTPUT_ALL_ONE: result = 1'b1;
         default:        result = 1'b0;
      endcase
   end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial WIDTH-bit ALU: one one_bit_alu slice, operands consumed LSB-first.
// Ports: clk_i/rst_i (sync, active high), start_i/f_i/a_i/b_i request,
//        busy_o/done_o handshake, registered result_o and carry/borrow/zero/
//        overflow flags. done_o pulses WIDTH+1 cycles after the accept cycle.
// Optional: define SERIAL_ALU_OVERFLOW_EN to build the signed overflow flag.
module serial_alu
   import serial_alu_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  logic [`CONTROL_WIDTH-1:0] f_i,
   input  logic [WIDTH-1:0]          a_i,
   input  logic [WIDTH-1:0]          b_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [WIDTH-1:0]          result_o,
   output logic                      carry_o,
   output logic                      borrow_o,
   output logic                      zero_o,
   output logic                      overflow_o
);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [WIDTH-1:0]  a_sh, b_sh, res_sh;
   ctrl_t             f_q;
   logic              carry_q, borrow_q;
   logic [WIDTH-1:0]  result_q;
   logic              carry_r, borrow_r;

   logic              slice_res, slice_carry, slice_borrow;
   logic              last_bit;
   logic              accept;
   logic [WIDTH-1:0]  res_next;

   one_bit_alu u_slice (
      .a          (a_sh[0]),
      .b          (b_sh[0]),
      .carry_in   (carry_q),
      .borrow_in  (borrow_q),
      .f          (f_q),
      .result     (slice_res),
      .carry_out  (slice_carry),
      .borrow_out (slice_borrow)
   );

   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
   assign accept   = (state_q == SERIAL_IDLE) && start_i;
   // Result register fills from the top, so after WIDTH shifts bit 0 is the LSB.
   assign res_next = {slice_res, res_sh[WIDTH-1:1]};

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= SERIAL_IDLE;
      else       state_q <= state_d;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d = state_q;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         SERIAL_IDLE: begin
            if (start_i) state_d = SERIAL_RUN;
         end
         SERIAL_RUN: begin
            busy_o = 1'b1;
            if (last_bit) state_d = SERIAL_DONE;
         end
         SERIAL_DONE: begin
            busy_o  = 1'b1;
            done_o  = 1'b1;
            state_d = SERIAL_IDLE;
         end
         default: state_d = SERIAL_IDLE;
      endcase
   end

   // Datapath: shift registers, inter-bit carry/borrow, counter, result flags.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         f_q      <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
         result_q <= '0;
         carry_r  <= 1'b0;
         borrow_r <= 1'b0;
      end else if (accept) begin
         a_sh     <= a_i;
         b_sh     <= b_i;
         f_q      <= f_i;
         res_sh   <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
      end else if (state_q == SERIAL_RUN) begin
         a_sh     <= a_sh >> 1;
         b_sh     <= b_sh >> 1;
         res_sh   <= res_next;
         carry_q  <= slice_carry;
         borrow_q <= slice_borrow;
         cnt_q    <= cnt_q + 1'b1;
         if (last_bit) begin
            result_q <= res_next;
            carry_r  <= (f_q == OUTPUT_A_PLUS_B)  && slice_carry;
            borrow_r <= (f_q == OUTPUT_A_MINUS_B) && slice_borrow;
         end
      end
   end

`ifdef SERIAL_ALU_OVERFLOW_EN
   logic a_msb_q, b_msb_q, ovf_r, ovf_d;

   // Overflow depends only on operand signs and result sign.
   always_comb begin
      ovf_d = 1'b0;
      if (f_q == OUTPUT_A_PLUS_B)
         ovf_d = (a_msb_q == b_msb_q) && (slice_res != a_msb_q);
      else if (f_q == OUTPUT_A_MINUS_B)
         ovf_d = (a_msb_q != b_msb_q) && (slice_res != a_msb_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_r   <= 1'b0;
      end else if (accept) begin
         a_msb_q <= a_i[WIDTH-1];
         b_msb_q <= b_i[WIDTH-1];
      end else if ((state_q == SERIAL_RUN) && last_bit && is_arith(f_q)) begin
         ovf_r <= ovf_d;
      end else if ((state_q == SERIAL_RUN) && last_bit) begin
         ovf_r <= 1'b0;
      end
   end

   assign overflow_o = ovf_r;
`else
   assign overflow_o = 1'b0;
`endif

   assign result_o = result_q;
   assign carry_o  = carry_r;
   assign borrow_o = borrow_r;
   assign zero_o   = (result_q == '0);

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu (WIDTH=8): directed and random operations
// compared against an arithmetic reference model, plus abort and back-to-back.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_serial_alu;
   import serial_alu_pkg::*;

   localparam int W = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   ctrl_t         f;
   logic [W-1:0]  a, b;
   logic          busy, done, carry, borrow, zero, ovf;
   logic [W-1:0]  result;

   int n_checks = 0;
   int n_fail   = 0;

   serial_alu #(.WIDTH(W)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .f_i        (f),
      .a_i        (a),
      .b_i        (b),
      .busy_o     (busy),
      .done_o     (done),
      .result_o   (result),
      .carry_o    (carry),
      .borrow_o   (borrow),
      .zero_o     (zero),
      .overflow_o (ovf)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model from plain integer arithmetic.
   task automatic model(input ctrl_t fo, input logic [W-1:0] ao, input logic [W-1:0] bo,
                        output logic [W-1:0] er, output logic ec, output logic eb, output logic eo);
      int unsigned ua, ub, s;
      int sa, sb, ss;
      ua = ao; ub = bo;
      sa = $signed(ao); sb = $signed(bo);
      er = '0; ec = 1'b0; eb = 1'b0; eo = 1'b0;
      case (fo)
         OUTPUT_A_PLUS_B: begin
            s  = ua + ub;
            er = W'(s % 256);
            ec = (s >= 256);
            ss = sa + sb;
            eo = (ss > 127) || (ss < -128);
         end
         OUTPUT_A_MINUS_B: begin
            er = W'((ua + 256 - ub) % 256);
            eb = (ua < ub);
            ss = sa - sb;
            eo = (ss > 127) || (ss < -128);
         end
         OUTPUT_A_AND_B: er = ao & bo;
         OUTPUT_A_OR_B:  er = ao | bo;
         OUTPUT_A_XOR_B: er = ao ^ bo;
         OUTPUT_NOT_A:   er = ~ao;
         OUTPUT_A:       er = ao;
         OUTPUT_B:       er = bo;
         OUTPUT_ALL_ONE: er = 8'hFF;
         default:        er = '0;
      endcase
`ifndef SERIAL_ALU_OVERFLOW_EN
      eo = 1'b0;
`endif
   endtask

   // Issue one operation; while busy, scramble inputs and pulse start (ignored).
   task automatic run_op(input ctrl_t fo, input logic [W-1:0] ao, input logic [W-1:0] bo,
                         input string tag);
      logic [W-1:0] er, prev;
      logic ec, eb, eo;
      int  cyc;
      bit  seen;
      model(fo, ao, bo, er, ec, eb, eo);
      @(negedge clk);
      prev  = result;
      start = 1'b1; f = fo; a = ao; b = bo;
      @(posedge clk);
      cyc  = 1;
      seen = 1'b0;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
         end else begin
            check_eq({tag, "_held"}, result, prev);
            a = W'($urandom); b = W'($urandom);
            f = ctrl_t'($urandom);
            start = 1'($urandom_range(0, 1));
            @(posedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
      check_eq({tag, "_latency"}, cyc, 9);
      check_eq({tag, "_busy"}, busy, 1'b1);
      check_eq({tag, "_result"}, result, er);
      check_eq({tag, "_carry"}, carry, ec);
      check_eq({tag, "_borrow"}, borrow, eb);
      check_eq({tag, "_zero"}, zero, (er == 0));
      check_eq({tag, "_ovf"}, ovf, eo);
      @(posedge clk);
      @(negedge clk);
      check_eq({tag, "_done_once"}, done, 1'b0);
      check_eq({tag, "_idle"}, busy, 1'b0);
      check_eq({tag, "_hold"}, result, er);
   endtask

   initial begin
      int dones;
      int done_idx[$];
      int idle_between;
      logic [W-1:0] er;
      logic ec, eb, eo;

      rst = 1'b1; start = 1'b0; f = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_result", result, 8'h00);
      check_eq("rst_carry", carry, 1'b0);
      check_eq("rst_borrow", borrow, 1'b0);
      check_eq("rst_zero", zero, 1'b1);
      check_eq("rst_ovf", ovf, 1'b0);

      // Directed cases.
      run_op(OUTPUT_A_PLUS_B,  8'h5A, 8'h3C, "plus_5a_3c");
      run_op(OUTPUT_A_MINUS_B, 8'h10, 8'h20, "minus_10_20");
      run_op(OUTPUT_A_PLUS_B,  8'hFF, 8'h01, "plus_ff_01");
      run_op(OUTPUT_A_XOR_B,   8'hA5, 8'hFF, "xor");
      run_op(OUTPUT_A_AND_B,   8'hA5, 8'hFF, "and");
      run_op(OUTPUT_A_OR_B,    8'hA5, 8'hFF, "or");
      run_op(OUTPUT_NOT_A,     8'hA5, 8'hFF, "not_a");
      run_op(OUTPUT_ALL_ZERO,  8'hA5, 8'hFF, "all_zero");
      run_op(OUTPUT_A_PLUS_B,  8'h01, 8'h01, "plus_01_01");
      run_op(OUTPUT_A_MINUS_B, 8'h80, 8'h01, "minus_80_01");
      run_op(ctrl_t'(13),      8'hFF, 8'hFF, "undef_13");

      // Abort three cycles into RUN.
      @(negedge clk);
      start = 1'b1; f = OUTPUT_A_PLUS_B; a = 8'h33; b = 8'h44;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_eq("abort_busy", busy, 1'b0);
      check_eq("abort_result", result, 8'h00);
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      check_eq("abort_no_done", dones, 0);
      run_op(OUTPUT_A_PLUS_B, 8'h7F, 8'h01, "plus_7f_01");

      // Random operations, including undefined opcodes.
      for (int i = 0; i < 40; i++) begin
         run_op(ctrl_t'($urandom_range(0, 15)), W'($urandom), W'($urandom), "rand");
      end

      // Back-to-back issue with start held high.
      model(OUTPUT_A_MINUS_B, 8'h21, 8'h43, er, ec, eb, eo);
      @(negedge clk);
      start = 1'b1; f = OUTPUT_A_MINUS_B; a = 8'h21; b = 8'h43;
      idle_between = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            if (done_idx.size() > 0) begin
               check_eq("b2b_period", i - done_idx[$], 10);
               check_eq("b2b_idle_gap", idle_between, 1);
            end
            check_eq("b2b_result", result, er);
            check_eq("b2b_borrow", borrow, eb);
            done_idx.push_back(i);
            idle_between = 0;
         end else if (!busy) begin
            idle_between++;
         end
      end
      start = 1'b0;
      check_eq("b2b_done_count", done_idx.size(), 5);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
